grid_sector_detect: RTL and testbench

Producer side of the rectifier switching interface. It classifies sampled three-phase grid voltages into a 60-degree sector and a half-sector flag, then filters the result and checks the sector sequence. It drives grid_sector and grid_judge into the rectifier switch decoder. It also provides grid_ok, which the top level ANDs into the rectifier SD enable.

---
 rtl/grid_sector_detect_pkg.sv | 50 +++++
 rtl/grid_sector_detect_if.sv | 24 ++
 rtl/grid_sector_classify.sv | 118 +++++++++++
 rtl/grid_sector_detect.sv | 145 ++++++++++++++
 tb/tb_grid_sector_detect.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/grid_sector_detect_pkg.sv
// Shared sector encoding, judge-condition encoding and sector sequencing helper
// for the grid sector detector.
package grid_pkg;

    typedef logic [2:0] sector_t;

    localparam sector_t SEC_NONE = 3'd0;
    localparam sector_t SEC_1    = 3'd1;
    localparam sector_t SEC_2    = 3'd2;
    localparam sector_t SEC_3    = 3'd3;
    localparam sector_t SEC_4    = 3'd4;
    localparam sector_t SEC_5    = 3'd5;
    localparam sector_t SEC_6    = 3'd6;

    // Comparison that decides the half-sector flag inside each sector
    typedef enum logic [2:0] {
        JC_B_LT_C = 3'd0,
        JC_A_GT_B = 3'd1,
        JC_C_LT_A = 3'd2,
        JC_B_GT_C = 3'd3,
        JC_A_LT_B = 3'd4,
        JC_C_GT_A = 3'd5,
        JC_NONE   = 3'd7
    } judge_cond_t;

    function automatic judge_cond_t judge_cond(input sector_t sec);
        judge_cond_t jc;
        case (sec)
            SEC_1:   jc = JC_B_LT_C;
            SEC_2:   jc = JC_A_GT_B;
            SEC_3:   jc = JC_C_LT_A;
            SEC_4:   jc = JC_B_GT_C;
            SEC_5:   jc = JC_A_LT_B;
            SEC_6:   jc = JC_C_GT_A;
            default: jc = JC_NONE;
        endcase
        return jc;
    endfunction

    function automatic sector_t next_sector(input sector_t sec, input logic rev);
        sector_t nxt;
        if (rev == 1'b0) begin
            nxt = (sec == SEC_6) ? SEC_1 : sec + 3'd1;
        end else begin
            nxt = (sec == SEC_1) ? SEC_6 : sec - 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/grid_sector_detect_if.sv
// Sample input and sector result bundle between the grid sampler and the
// rectifier switch decoder.
interface grid_sector_detect_if #(parameter int DW = 16);
    logic signed [DW-1:0] va;
    logic signed [DW-1:0] vb;
    logic signed [DW-1:0] vc;
    logic                 sample_valid;
    logic                 clear_err;
    logic [15:0]          grid_sector;
    logic                 grid_judge;
    logic                 sector_upd;
    logic                 grid_ok;
    logic                 seq_err;

    modport master (
        output va, vb, vc, sample_valid, clear_err,
        input  grid_sector, grid_judge, sector_upd, grid_ok, seq_err
    );

    modport slave (
        input  va, vb, vc, sample_valid, clear_err,
        output grid_sector, grid_judge, sector_upd, grid_ok, seq_err
    );
endinterface

// File: rtl/grid_sector_classify.sv
// Two-stage raw classifier: saturating magnitudes, then dominant phase,
// sector, half-sector flag and presence check.
module grid_sector_classify
    import grid_pkg::*;
#(
    parameter int DW   = 16,
    parameter int VMIN = 2000
) (
    input  logic                 sysclk,
    input  logic                 global_rst,
    input  logic signed [DW-1:0] va,
    input  logic signed [DW-1:0] vb,
    input  logic signed [DW-1:0] vc,
    input  logic                 sample_valid,
    output logic                 raw_stb,
    output logic                 raw_ok,
    output sector_t              raw_sec,
    output logic                 raw_judge
);

    localparam int MW = DW - 1;
    localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};
    localparam logic [MW-1:0] VMIN_C  = MW'(VMIN);

    // Most negative code has no positive twin, so it clamps to full scale
    function automatic logic [MW-1:0] mag_of(input logic signed [DW-1:0] v);
        logic signed [DW-1:0] neg;
        logic [MW-1:0]        mag;
        neg = -v;
        if (v[DW-1] == 1'b0) begin
            mag = v[MW-1:0];
        end else if (neg[DW-1] == 1'b1) begin
            mag = MAG_MAX;
        end else begin
            mag = neg[MW-1:0];
        end
        return mag;
    endfunction

    logic                 s1_vld_r;
    logic signed [DW-1:0] s1_va_r, s1_vb_r, s1_vc_r;
    logic [MW-1:0]        s1_ma_r, s1_mb_r, s1_mc_r;
    logic [MW-1:0]        dom_mag_s;
    sector_t              sec_s;
    logic                 judge_s;
    logic                 raw_stb_r, raw_ok_r, raw_judge_r;
    sector_t              raw_sec_r;

    // Stage 1: capture samples and their magnitudes
    always_ff @(posedge sysclk or posedge global_rst) begin
        if (global_rst) begin
            s1_vld_r <= 1'b0;
            s1_va_r  <= '0;
            s1_vb_r  <= '0;
            s1_vc_r  <= '0;
            s1_ma_r  <= '0;
            s1_mb_r  <= '0;
            s1_mc_r  <= '0;
        end else begin
            s1_vld_r <= sample_valid;
            if (sample_valid) begin
                s1_va_r <= va;
                s1_vb_r <= vb;
                s1_vc_r <= vc;
                s1_ma_r <= mag_of(va);
                s1_mb_r <= mag_of(vb);
                s1_mc_r <= mag_of(vc);
            end
        end
    end

    // Dominant phase (ties favour A, then B) selects sector and judge test
    always_comb begin
        dom_mag_s = s1_ma_r;
        sec_s     = SEC_NONE;
        judge_s   = 1'b0;
        if ((s1_ma_r >= s1_mb_r) && (s1_ma_r >= s1_mc_r)) begin
            dom_mag_s = s1_ma_r;
            sec_s     = s1_va_r[DW-1] ? SEC_4 : SEC_1;
        end else if (s1_mb_r >= s1_mc_r) begin
            dom_mag_s = s1_mb_r;
            sec_s     = s1_vb_r[DW-1] ? SEC_6 : SEC_3;
        end else begin
            dom_mag_s = s1_mc_r;
            sec_s     = s1_vc_r[DW-1] ? SEC_2 : SEC_5;
        end
        case (judge_cond(sec_s))
            JC_B_LT_C: judge_s = (s1_vb_r < s1_vc_r);
            JC_A_GT_B: judge_s = (s1_va_r > s1_vb_r);
            JC_C_LT_A: judge_s = (s1_vc_r < s1_va_r);
            JC_B_GT_C: judge_s = (s1_vb_r > s1_vc_r);
            JC_A_LT_B: judge_s = (s1_va_r < s1_vb_r);
            JC_C_GT_A: judge_s = (s1_vc_r > s1_va_r);
            default:   judge_s = 1'b0;
        endcase
    end

    // Stage 2: register raw classification
    always_ff @(posedge sysclk or posedge global_rst) begin
        if (global_rst) begin
            raw_stb_r   <= 1'b0;
            raw_ok_r    <= 1'b0;
            raw_sec_r   <= SEC_NONE;
            raw_judge_r <= 1'b0;
        end else begin
            raw_stb_r   <= s1_vld_r;
            raw_ok_r    <= (dom_mag_s >= VMIN_C);
            raw_sec_r   <= sec_s;
            raw_judge_r <= judge_s;
        end
    end

    assign raw_stb   = raw_stb_r;
    assign raw_ok    = raw_ok_r;
    assign raw_sec   = raw_sec_r;
    assign raw_judge = raw_judge_r;

endmodule

// File: rtl/grid_sector_detect.sv
// Grid sector detector: raw classification, confirm filter, sequence
// checker with lock counter, and loss-of-grid timeout.
module grid_sector_detect
    import grid_pkg::*;
#(
    parameter int DW      = 16,
    parameter int CONFIRM = 4,
    parameter int VMIN    = 2000,
    parameter int TIMEOUT = 2_000_000,
    parameter int LOCK_N  = 6,
    parameter int REV     = 0
) (
    input  logic                 sysclk,
    input  logic                 global_rst,
    grid_sector_detect_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_N + 1);
    localparam logic [3:0]    CONFIRM_C = 4'(CONFIRM);
    localparam logic [TW-1:0] TMO_C     = TW'(TIMEOUT);
    localparam logic [LW-1:0] LOCK_C    = LW'(LOCK_N);
    localparam logic          REV_B     = (REV != 0) ? 1'b1 : 1'b0;

    logic          raw_stb_s, raw_ok_s, raw_judge_s;
    sector_t       raw_sec_s;
    logic [3:0]    cnt_r, cnt_s;
    sector_t       cand_sec_r, cand_sec_s, sec_r, sec_s;
    logic          cand_judge_r, cand_judge_s, judge_r, judge_s;
    logic          upd_r, upd_s, ok_r, ok_s, err_r, err_s;
    logic [LW-1:0] lock_r, lock_s;
    logic [TW-1:0] tmo_r, tmo_s;
    logic          tmo_hit_s, sec_chg_s, err_set_s;

    grid_sector_classify #(.DW(DW), .VMIN(VMIN)) u_classify (
        .sysclk       (sysclk),
        .global_rst   (global_rst),
        .va           (bus.va),
        .vb           (bus.vb),
        .vc           (bus.vc),
        .sample_valid (bus.sample_valid),
        .raw_stb      (raw_stb_s),
        .raw_ok       (raw_ok_s),
        .raw_sec      (raw_sec_s),
        .raw_judge    (raw_judge_s)
    );

    // Confirm filter, sequence check, lock and timeout next-state
    always_comb begin
        cnt_s        = cnt_r;
        cand_sec_s   = cand_sec_r;
        cand_judge_s = cand_judge_r;
        sec_s        = sec_r;
        judge_s      = judge_r;
        upd_s        = 1'b0;
        sec_chg_s    = 1'b0;
        err_set_s    = 1'b0;
        tmo_hit_s    = (tmo_r == TMO_C);
        lock_s       = tmo_hit_s ? '0 : lock_r;

        if (raw_stb_s && !raw_ok_s) begin
            cnt_s = 4'd0;
        end else if (raw_stb_s && (raw_sec_s == cand_sec_r) && (raw_judge_s == cand_judge_r)) begin
            cnt_s = (cnt_r >= CONFIRM_C) ? CONFIRM_C : cnt_r + 4'd1;
        end else if (raw_stb_s) begin
            cand_sec_s   = raw_sec_s;
            cand_judge_s = raw_judge_s;
            cnt_s        = 4'd1;
        end else begin
            cnt_s = cnt_r;
        end

        if (raw_stb_s && raw_ok_s && (cnt_s == CONFIRM_C) &&
            ((cand_sec_s != sec_r) || (cand_judge_s != judge_r))) begin
            sec_s     = cand_sec_s;
            judge_s   = cand_judge_s;
            upd_s     = 1'b1;
            sec_chg_s = (cand_sec_s != sec_r);
        end else begin
            upd_s = 1'b0;
        end

        // First acquisition or re-acquisition after loss is taken unchecked
        if (!sec_chg_s || (sec_r == SEC_NONE) || tmo_hit_s) begin
            err_set_s = 1'b0;
        end else if (cand_sec_s == next_sector(sec_r, REV_B)) begin
            lock_s = (lock_r >= LOCK_C) ? LOCK_C : lock_r + LW'(1);
        end else begin
            lock_s    = '0;
            err_set_s = 1'b1;
        end

        if (sec_chg_s) begin
            tmo_s = '0;
        end else if (tmo_hit_s) begin
            tmo_s = tmo_r;
        end else begin
            tmo_s = tmo_r + TW'(1);
        end

        if (err_set_s) begin
            err_s = 1'b1;
        end else if (bus.clear_err) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end

        ok_s = (lock_s == LOCK_C);
    end

    // Filter, checker and output registers
    always_ff @(posedge sysclk or posedge global_rst) begin
        if (global_rst) begin
            cnt_r        <= 4'd0;
            cand_sec_r   <= SEC_NONE;
            cand_judge_r <= 1'b0;
            sec_r        <= SEC_NONE;
            judge_r      <= 1'b0;
            upd_r        <= 1'b0;
            ok_r         <= 1'b0;
            err_r        <= 1'b0;
            lock_r       <= '0;
            tmo_r        <= '0;
        end else begin
            cnt_r        <= cnt_s;
            cand_sec_r   <= cand_sec_s;
            cand_judge_r <= cand_judge_s;
            sec_r        <= sec_s;
            judge_r      <= judge_s;
            upd_r        <= upd_s;
            ok_r         <= ok_s;
            err_r        <= err_s;
            lock_r       <= lock_s;
            tmo_r        <= tmo_s;
        end
    end

    assign bus.grid_sector = {13'd0, sec_r};
    assign bus.grid_judge  = judge_r;
    assign bus.sector_upd  = upd_r;
    assign bus.grid_ok     = ok_r;
    assign bus.seq_err     = err_r;

endmodule

// File: tb/tb_grid_sector_detect.sv
// Scoreboard bench for grid_sector_detect: directed sample vectors push the
// expected sector update; a negedge monitor matches every sector_upd.
module tb_grid_sector_detect;

    typedef struct {
        int sec;
        int judge;
        int ok;
        int err;
        int cyc;
    } exp_t;

    logic sysclk;
    logic global_rst;
    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Phase vectors for sectors 1..6, all with the half-sector flag set
    logic signed [15:0] tab_a [6] = '{16'sd20000,  16'sd12000, -16'sd8000, -16'sd20000, -16'sd12000,  16'sd8000};
    logic signed [15:0] tab_b [6] = '{-16'sd12000, 16'sd8000,  16'sd20000, 16'sd12000,  -16'sd8000,  -16'sd20000};
    logic signed [15:0] tab_c [6] = '{-16'sd8000, -16'sd20000, -16'sd12000, 16'sd8000,   16'sd20000,  16'sd12000};

    grid_sector_detect_if #(.DW(16)) bus0 ();
    grid_sector_detect_if #(.DW(16)) bus1 ();

    assign bus1.va           = bus0.va;
    assign bus1.vb           = bus0.vb;
    assign bus1.vc           = bus0.vc;
    assign bus1.sample_valid = bus0.sample_valid;
    assign bus1.clear_err    = bus0.clear_err;

    grid_sector_detect #(.DW(16), .CONFIRM(4), .VMIN(2000), .TIMEOUT(400), .LOCK_N(6), .REV(0)) dut (
        .sysclk     (sysclk),
        .global_rst (global_rst),
        .bus        (bus0)
    );

    grid_sector_detect #(.DW(16), .CONFIRM(4), .VMIN(2000), .TIMEOUT(400), .LOCK_N(6), .REV(1)) dut_rev (
        .sysclk     (sysclk),
        .global_rst (global_rst),
        .bus        (bus1)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [15:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            bus0.va           = a;
            bus0.vb           = b;
            bus0.vc           = c;
            bus0.sample_valid = 1'b1;
            last_cyc          = cyc;
        end
        @(negedge sysclk);
        bus0.sample_valid = 1'b0;
    endtask

    task automatic expect_upd(input int sec, input int judge, input int ok, input int err);
        exp_t e;
        e.sec   = sec;
        e.judge = judge;
        e.ok    = ok;
        e.err   = err;
        e.cyc   = last_cyc + 3;
        sb_q.push_back(e);
    endtask

    // Monitor: every sector_upd must match the oldest expectation, on time
    always @(negedge sysclk) begin
        exp_t e;
        if ((sb_q.size() > 0) && (cyc > sb_q[0].cyc)) begin
            checks++;
            errors++;
            $display("FAIL upd_missing actual none required sector %0d at cycle %0d", sb_q[0].sec, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (bus0.sector_upd === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_unexpected actual sector %0d judge %0d required no update (cycle %0d)",
                         bus0.grid_sector, bus0.grid_judge, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("upd_cycle", cyc, e.cyc);
                chk("upd_sector", int'(bus0.grid_sector), e.sec);
                chk("upd_judge", int'(bus0.grid_judge), e.judge);
                chk("upd_grid_ok", int'(bus0.grid_ok), e.ok);
                chk("upd_seq_err", int'(bus0.seq_err), e.err);
            end
        end
    end

    initial begin
        int s;
        global_rst        = 1'b1;
        bus0.va           = 16'sd0;
        bus0.vb           = 16'sd0;
        bus0.vc           = 16'sd0;
        bus0.sample_valid = 1'b0;
        bus0.clear_err    = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge sysclk);
            bus0.va           = 16'($urandom);
            bus0.vb           = 16'($urandom);
            bus0.vc           = 16'($urandom);
            bus0.sample_valid = 1'($urandom_range(0, 1));
        end
        chk("rst_sector", int'(bus0.grid_sector), 0);
        chk("rst_judge", int'(bus0.grid_judge), 0);
        chk("rst_upd", int'(bus0.sector_upd), 0);
        chk("rst_grid_ok", int'(bus0.grid_ok), 0);
        chk("rst_seq_err", int'(bus0.seq_err), 0);
        @(negedge sysclk);
        bus0.sample_valid = 1'b0;
        global_rst        = 1'b0;
        idle(4);

        // Acquisition needs all four confirming samples
        send(tab_a[0], tab_b[0], tab_c[0], 3);
        idle(6);
        chk("pre_confirm_sector", int'(bus0.grid_sector), 0);
        send(tab_a[0], tab_b[0], tab_c[0], 1);
        expect_upd(1, 1, 0, 0);
        idle(6);

        // Short burst of sector 2 is filtered out
        send(tab_a[1], tab_b[1], tab_c[1], 3);
        send(tab_a[0], tab_b[0], tab_c[0], 4);
        idle(6);
        chk("glitch_sector", int'(bus0.grid_sector), 1);

        // Judge-only change within sector 1
        send(16'sd20000, -16'sd8000, -16'sd12000, 4);
        expect_upd(1, 0, 0, 0);
        idle(6);
        send(tab_a[0], tab_b[0], tab_c[0], 4);
        expect_upd(1, 1, 0, 0);
        idle(6);

        // 1 -> 3 skips a sector
        send(tab_a[2], tab_b[2], tab_c[2], 4);
        expect_upd(3, 1, 0, 1);
        idle(6);
        @(negedge sysclk);
        bus0.clear_err = 1'b1;
        @(negedge sysclk);
        bus0.clear_err = 1'b0;
        idle(2);
        chk("clear_err", int'(bus0.seq_err), 0);

        // Six in-order transitions 3->4->5->6->1->2->3 reach lock
        for (int k = 0; k < 6; k++) begin
            s = ((3 + k) % 6) + 1;
            send(tab_a[s-1], tab_b[s-1], tab_c[s-1], 4);
            expect_upd(s, 1, (k == 5) ? 1 : 0, 0);
            idle(4);
        end
        chk("rev_seq_err", int'(bus1.seq_err), 1);
        chk("rev_grid_ok", int'(bus1.grid_ok), 0);
        chk("rev_sector", int'(bus1.grid_sector), 3);

        // Grid loss: weak samples until the timeout expires
        send(16'sd1000, -16'sd500, -16'sd500, 100);
        chk("loss_early_ok", int'(bus0.grid_ok), 1);
        send(16'sd1000, -16'sd500, -16'sd500, 350);
        idle(4);
        chk("loss_grid_ok", int'(bus0.grid_ok), 0);
        chk("loss_sector", int'(bus0.grid_sector), 3);
        chk("loss_judge", int'(bus0.grid_judge), 1);

        // After the timeout an out-of-order sector is taken unchecked
        send(tab_a[0], tab_b[0], tab_c[0], 4);
        expect_upd(1, 1, 0, 0);
        idle(6);

        // Most negative code saturates: sector 4, flag 0, and 1->4 is an error
        send(16'sh8000, 16'sd0, 16'sd0, 4);
        expect_upd(4, 0, 0, 1);
        idle(6);

        // Reset while a confirmed sample is still in the pipeline
        send(tab_a[1], tab_b[1], tab_c[1], 4);
        global_rst = 1'b1;
        idle(3);
        global_rst = 1'b0;
        idle(8);
        chk("rst_flush_sector", int'(bus0.grid_sector), 0);
        chk("rst_flush_seq_err", int'(bus0.seq_err), 0);
        chk("rst_flush_grid_ok", int'(bus0.grid_ok), 0);

        idle(4);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
